reg_rsv_tracker: RTL

Per-register write-reservation tracker for the issue stage. It counts outstanding in-flight writers to each architectural register, because WAW is not stalled. Reservations come from the issuer, up to 2 per cycle. Releases come from the committer's three register-file write ports. Source-operand busy status goes back to the issuer. A flush clears all reservations.

---
 rtl/reg_rsv_tracker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_rsv_tracker.sv
// reg_rsv_tracker: counts in-flight writers per architectural register.
// Reservations arrive from the issuer (2 slots) and releases from the 3 commit
// write ports. Registered counters drive the busy vectors back to the issuer.
// Optional feature macro: RSV_UNDERFLOW_CHK_EN adds a sticky flag for a release
// that arrives with no matching reservation.
module reg_rsv_tracker #(
    parameter int CntW = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  rsv_valid_i,
    input  logic [4:0]  rsv_addr0_i,
    input  logic [4:0]  rsv_addr1_i,
    output logic        rsv_rdy_o,
    input  logic [2:0]  cmt_we_i,
    input  logic [2:0]  cmt_wrsv_i,
    input  logic [4:0]  cmt_waddr0_i,
    input  logic [4:0]  cmt_waddr1_i,
    input  logic [4:0]  cmt_waddr2_i,
    input  logic        flush_i,
    input  logic [19:0] rs_addr_i,
    output logic [3:0]  rs_busy_o,
    output logic [31:0] reg_busy_o,
    output logic        idle_o,
    output logic        rsv_underflow_o
);
    // Sums are kept two bits wider so cnt + inc never wraps before comparison.
    localparam int SumW = CntW + 2;
    localparam logic [SumW-1:0] MaxCnt = SumW'((1 << CntW) - 1);

    // Entry 0 is held at zero so that address x0 reads as never busy.
    logic [CntW-1:0] cnt_q [32];
    logic [CntW-1:0] cnt_d [32];
    logic [1:0]      inc_c [32];
    logic [1:0]      dec_c [32];
    logic [1:0]      rsv_acc;
    logic [SumW-1:0] slot_need;
    logic [2:0]      rel_en;
    logic [4:0]      waddr [3];

    // Saturating update: a release exceeding the available count floors at 0.
    function automatic logic [CntW-1:0] sat_update(input logic [CntW-1:0] cnt,
                                                   input logic [1:0]      inc,
                                                   input logic [1:0]      dec);
        logic [SumW-1:0] sum;
        sum = SumW'(cnt) + SumW'(inc);
        if (SumW'(dec) > sum) return '0;
        return CntW'(sum - SumW'(dec));
    endfunction

    assign waddr[0] = cmt_waddr0_i;
    assign waddr[1] = cmt_waddr1_i;
    assign waddr[2] = cmt_waddr2_i;
    assign rel_en   = cmt_we_i & cmt_wrsv_i;

    // Admission check: all-or-nothing, ignores same-cycle releases and flush.
    always_comb begin
        rsv_rdy_o = 1'b1;
        slot_need = (rsv_valid_i[0] && rsv_valid_i[1] && (rsv_addr0_i == rsv_addr1_i))
                    ? SumW'(2) : SumW'(1);
        if (rsv_valid_i[0] && (rsv_addr0_i != 5'd0) &&
            (SumW'(cnt_q[rsv_addr0_i]) + slot_need > MaxCnt))
            rsv_rdy_o = 1'b0;
        if (rsv_valid_i[1] && (rsv_addr1_i != 5'd0) &&
            (SumW'(cnt_q[rsv_addr1_i]) + slot_need > MaxCnt))
            rsv_rdy_o = 1'b0;
    end

    // Per-register increment/decrement counts and next counter values.
    always_comb begin
        rsv_acc = rsv_valid_i & {2{rsv_rdy_o}};
        for (int i = 0; i < 32; i++) begin
            inc_c[i] = 2'(rsv_acc[0] && (rsv_addr0_i == 5'(i))) +
                       2'(rsv_acc[1] && (rsv_addr1_i == 5'(i)));
            dec_c[i] = 2'(rel_en[0] && (waddr[0] == 5'(i))) +
                       2'(rel_en[1] && (waddr[1] == 5'(i))) +
                       2'(rel_en[2] && (waddr[2] == 5'(i)));
            cnt_d[i] = sat_update(cnt_q[i], inc_c[i], dec_c[i]);
        end
        inc_c[0] = '0;
        dec_c[0] = '0;
        cnt_d[0] = '0;
    end

    // Counter state; flush discards everything including same-cycle traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Busy decode from registered counters only; no bypass of current traffic.
    always_comb begin
        reg_busy_o = '0;
        for (int i = 1; i < 32; i++) reg_busy_o[i] = |cnt_q[i];
        for (int j = 0; j < 4; j++) rs_busy_o[j] = reg_busy_o[rs_addr_i[j*5 +: 5]];
        idle_o = ~|reg_busy_o;
    end

`ifdef RSV_UNDERFLOW_CHK_EN
    logic        uf_q;
    logic [31:0] uf_c;

    // Flag registers whose release count exceeds count plus new reservations.
    always_comb begin
        uf_c = '0;
        for (int i = 1; i < 32; i++)
            uf_c[i] = SumW'(dec_c[i]) > (SumW'(cnt_q[i]) + SumW'(inc_c[i]));
    end

    // Sticky underflow flag; flush clears it and masks a same-cycle underflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        uf_q <= 1'b0;
        else if (flush_i)   uf_q <= 1'b0;
        else if (|uf_c)     uf_q <= 1'b1;
    end

`ifndef SYNTHESIS
    // Simulation-only report naming the offending register.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i)
            for (int i = 1; i < 32; i++)
                if (uf_c[i]) $warning("reg_rsv_tracker: release of x%0d without reservation", i);
    end
`endif

    assign rsv_underflow_o = uf_q;
`else
    assign rsv_underflow_o = 1'b0;
`endif

endmodule
